// File: rtl/tile_sequencer_if.sv
// Handshake bundle between a run controller (master) and the tile sequencer (slave).
// Carries start/abort/tile count in, buffer-read and switch strobes plus output-row tracking out.
interface tile_sequencer_if #(
  parameter int A_ROWS = 16,
  parameter int TILE_W = 8
);
  localparam int RW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;

  logic              start;
  logic              abort;
  logic [TILE_W-1:0] num_tiles;
  logic              w_read;
  logic              if_read;
  logic              switch;
  logic              of_valid;
  logic [RW-1:0]     of_row;
  logic [TILE_W-1:0] of_tile;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, num_tiles,
    input  w_read, if_read, switch, of_valid, of_row, of_tile, busy, done
  );

  modport slave (
    input  start, abort, num_tiles,
    output w_read, if_read, switch, of_valid, of_row, of_tile, busy, done
  );
endinterface

// File: rtl/tile_sequencer.sv
// Multi-tile control sequencer for the weight-stationary systolic array: preloads the next
// tile's weights while the current one streams, and tracks which output row is leaving the array.
module tile_sequencer #(
  parameter int ROWS   = 8,
  parameter int A_ROWS = 16,
  parameter int LAT    = 15,
  parameter int TILE_W = 8
) (
  input  logic clk,
  input  logic rst,
  tile_sequencer_if.slave bus
);

  localparam int PMAX = (ROWS > A_ROWS) ? ((ROWS > LAT) ? ROWS : LAT)
                                        : ((A_ROWS > LAT) ? A_ROWS : LAT);
  localparam int PW = $clog2(PMAX + 1);
  localparam int SW = $clog2(A_ROWS + LAT + 1);
  localparam int RW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;

  localparam logic [PW-1:0] ROWS_CNT   = PW'(ROWS);
  localparam logic [PW-1:0] ROWS_END   = PW'(ROWS - 1);
  localparam logic [PW-1:0] STREAM_END = PW'(A_ROWS - 1);
  localparam logic [PW-1:0] DRAIN_END  = PW'(LAT - 1);
  localparam logic [SW-1:0] LAT_IDX    = SW'(LAT);
  localparam logic [SW-1:0] AROWS_IDX  = SW'(A_ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_SWITCH, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_n;
  logic [PW-1:0]     phase_q, phase_n;
  logic [TILE_W-1:0] tile_q, tile_n;
  logic [TILE_W-1:0] count_q, count_n;

  logic              w_read_q, if_read_q, switch_q, of_valid_q, busy_q, done_q;
  logic [RW-1:0]     of_row_q;
  logic [TILE_W-1:0] of_tile_q;

  logic [SW-1:0]     sidx_n;
  logic              in_win_n;
  logic              w_read_n;

  // Widened compare so a count of 2^TILE_W-1 never wraps.
  function automatic logic tiles_remain(input logic [TILE_W-1:0] idx,
                                        input logic [TILE_W-1:0] cnt);
    return ({1'b0, idx} + {{TILE_W{1'b0}}, 1'b1}) < {1'b0, cnt};
  endfunction

  // Cycle index measured from the first STREAM cycle of the current tile.
  function automatic logic [SW-1:0] stream_idx(input state_t st, input logic [PW-1:0] ph);
    if (st == S_DRAIN) return AROWS_IDX + SW'(ph);
    return SW'(ph);
  endfunction

  always_comb begin
    state_n = state_q;
    phase_n = phase_q + PW'(1);
    tile_n  = tile_q;
    count_n = count_q;
    unique case (state_q)
      S_IDLE: begin
        phase_n = '0;
        if (bus.start && !bus.abort) begin
          count_n = bus.num_tiles;
          tile_n  = '0;
          state_n = (bus.num_tiles == '0) ? S_DONE : S_PRELOAD;
        end
      end
      S_PRELOAD: begin
        if (phase_q == ROWS_END) begin
          state_n = S_SWITCH;
          phase_n = '0;
        end
      end
      S_SWITCH: begin
        state_n = S_STREAM;
        phase_n = '0;
      end
      S_STREAM: begin
        if (phase_q == STREAM_END) begin
          state_n = S_DRAIN;
          phase_n = '0;
        end
      end
      S_DRAIN: begin
        if (phase_q == DRAIN_END) begin
          tile_n  = tile_q + TILE_W'(1);
          phase_n = '0;
          state_n = tiles_remain(tile_q, count_q) ? S_SWITCH : S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        phase_n = '0;
      end
      default: begin
        state_n = S_IDLE;
        phase_n = '0;
      end
    endcase
    if (bus.abort) begin
      state_n = S_IDLE;
      phase_n = '0;
    end

    // Outputs are precomputed from the next state so they register in step with it.
    sidx_n   = stream_idx(state_n, phase_n);
    in_win_n = ((state_n == S_STREAM) || (state_n == S_DRAIN)) && (sidx_n >= LAT_IDX);
    w_read_n = (state_n == S_PRELOAD) ||
               ((state_n == S_STREAM) && (phase_n < ROWS_CNT) && tiles_remain(tile_n, count_n));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      tile_q     <= '0;
      count_q    <= '0;
      w_read_q   <= 1'b0;
      if_read_q  <= 1'b0;
      switch_q   <= 1'b0;
      of_valid_q <= 1'b0;
      of_row_q   <= '0;
      of_tile_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      phase_q    <= phase_n;
      tile_q     <= tile_n;
      count_q    <= count_n;
      w_read_q   <= w_read_n;
      if_read_q  <= (state_n == S_STREAM);
      switch_q   <= (state_n == S_SWITCH);
      of_valid_q <= in_win_n;
      of_row_q   <= in_win_n ? RW'(sidx_n - LAT_IDX) : '0;
      of_tile_q  <= tile_n;
      busy_q     <= (state_n != S_IDLE);
      done_q     <= (state_n == S_DONE);
    end
  end

  assign bus.w_read   = w_read_q;
  assign bus.if_read  = if_read_q;
  assign bus.switch   = switch_q;
  assign bus.of_valid = of_valid_q;
  assign bus.of_row   = of_row_q;
  assign bus.of_tile  = of_tile_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: stimulus pushes tagged expected output vectors,
// per-DUT monitors pop and compare them on the falling edge.
module tb_tile_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_sequencer_if #(.A_ROWS(16), .TILE_W(8)) bus0 ();
  tile_sequencer_if #(.A_ROWS(4),  .TILE_W(8)) bus1 ();

  tile_sequencer #(.ROWS(8), .A_ROWS(16), .LAT(15), .TILE_W(8)) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  tile_sequencer #(.ROWS(4), .A_ROWS(4), .LAT(7), .TILE_W(8)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct packed {
    logic       w;
    logic       i;
    logic       s;
    logic       v;
    logic [7:0] row;
    logic [7:0] tile;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    int   tag;
    out_t v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t h0, h1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  out_t obs0, obs1;
  assign obs0 = {bus0.w_read, bus0.if_read, bus0.switch, bus0.of_valid, 8'(bus0.of_row),
                 bus0.of_tile, bus0.busy, bus0.done};
  assign obs1 = {bus1.w_read, bus1.if_read, bus1.switch, bus1.of_valid, 8'(bus1.of_row),
                 bus1.of_tile, bus1.busy, bus1.done};

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for run-relative cycle r (cycle 1 = first cycle after the start edge).
  function automatic out_t model(input int r, input int rows, input int ar, input int lat,
                                 input int nt);
    out_t o;
    int per, dn, k, p, sidx;
    o = '0;
    per = 1 + ar + lat;
    if (r < 1) return o;
    if (nt == 0) begin
      o.busy = (r == 1);
      o.done = (r == 1);
      return o;
    end
    dn = rows + 1 + nt * per;
    if (r <= dn) o.busy = 1'b1;
    if (r == dn) o.done = 1'b1;
    if (r <= rows) o.w = 1'b1;
    if (r > rows && r < dn) begin
      k = (r - rows - 1) / per;
      p = (r - rows - 1) % per;
      if (p == 0) o.s = 1'b1;
      else begin
        sidx = p - 1;
        if (sidx < ar) begin
          o.i = 1'b1;
          if (sidx < rows && k < nt - 1) o.w = 1'b1;
        end
        if (sidx >= lat) begin
          o.v    = 1'b1;
          o.row  = 8'(sidx - lat);
          o.tile = 8'(k);
        end
      end
    end
    return o;
  endfunction

  function automatic int run_len(input int rows, input int ar, input int lat, input int nt);
    return (nt == 0) ? 1 : rows + 1 + nt * (1 + ar + lat);
  endfunction

  task automatic push_run(input int dut, input int e0, input int r_lo, input int r_hi,
                          input int rows, input int ar, input int lat, input int nt);
    exp_t e;
    for (int r = r_lo; r <= r_hi; r++) begin
      e.tag = e0 + r - 1;
      e.v   = model(r, rows, ar, lat, nt);
      if (dut == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  task automatic push_zero(input int dut, input int t_lo, input int t_hi);
    exp_t e;
    for (int t = t_lo; t <= t_hi; t++) begin
      e.tag = t;
      e.v   = '0;
      if (dut == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  task automatic compare(input string nm, input int tag, input out_t got, input out_t want);
    out_t g, w;
    g = got;
    w = want;
    if (!w.v) begin
      g.row = '0; g.tile = '0; w.row = '0; w.tile = '0;
    end
    checks++;
    if (g !== w) begin
      failures++;
      $display("FAIL %s cyc=%0d got w_read=%b if_read=%b switch=%b of_valid=%b of_row=%0d of_tile=%0d busy=%b done=%b required w_read=%b if_read=%b switch=%b of_valid=%b of_row=%0d of_tile=%0d busy=%b done=%b",
               nm, tag, got.w, got.i, got.s, got.v, got.row, got.tile, got.busy, got.done,
               want.w, want.i, want.s, want.v, want.row, want.tile, want.busy, want.done);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() != 0 && q0[0].tag <= cyc) begin
      h0 = q0.pop_front();
      if (h0.tag == cyc) compare("u0_outputs", h0.tag, obs0, h0.v);
      else begin
        checks++;
        failures++;
        $display("FAIL u0_stale expected tag=%0d still queued at cyc=%0d", h0.tag, cyc);
      end
    end
    if (q1.size() != 0 && q1[0].tag <= cyc) begin
      h1 = q1.pop_front();
      if (h1.tag == cyc) compare("u1_outputs", h1.tag, obs1, h1.v);
      else begin
        checks++;
        failures++;
        $display("FAIL u1_stale expected tag=%0d still queued at cyc=%0d", h1.tag, cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int e, e1, len0, len6, len255;

  initial begin
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.num_tiles = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.num_tiles = '0;
    len0 = run_len(8, 16, 15, 1);

    // Reset state on both DUTs.
    step();
    push_zero(0, cyc + 1, cyc + 2);
    push_zero(1, cyc + 1, cyc + 2);
    step();
    step();
    rst = 1'b0;
    step();

    // Single tile.
    e = cyc + 1;
    bus0.num_tiles = 8'd1; bus0.start = 1'b1;
    push_run(0, e, 1, len0 + 1, 8, 16, 15, 1);
    step();
    bus0.start = 1'b0;
    repeat (len0 + 2) step();

    // Two tiles.
    e = cyc + 1;
    bus0.num_tiles = 8'd2; bus0.start = 1'b1;
    push_run(0, e, 1, run_len(8, 16, 15, 2) + 1, 8, 16, 15, 2);
    step();
    bus0.start = 1'b0;
    repeat (run_len(8, 16, 15, 2) + 2) step();

    // Zero tiles.
    e = cyc + 1;
    bus0.num_tiles = 8'd0; bus0.start = 1'b1;
    push_run(0, e, 1, 3, 8, 16, 15, 0);
    step();
    bus0.start = 1'b0;
    repeat (4) step();

    // abort together with start in IDLE: nothing starts.
    push_zero(0, cyc + 1, cyc + 4);
    bus0.num_tiles = 8'd1; bus0.start = 1'b1; bus0.abort = 1'b1;
    step();
    bus0.start = 1'b0; bus0.abort = 1'b0;
    repeat (5) step();

    // Abort mid-stream at cycle 15, restart at cycle 20.
    e = cyc + 1;
    bus0.num_tiles = 8'd1; bus0.start = 1'b1;
    push_run(0, e, 1, 15, 8, 16, 15, 1);
    push_zero(0, e + 15, e + 19);
    step();
    bus0.start = 1'b0;
    while (cyc < e + 14) step();
    bus0.abort = 1'b1;
    step();
    bus0.abort = 1'b0;
    while (cyc < e + 19) step();
    e1 = cyc + 1;
    bus0.start = 1'b1;
    push_run(0, e1, 1, len0 + 1, 8, 16, 15, 1);
    step();
    bus0.start = 1'b0;
    repeat (len0 + 2) step();

    // Reset during DRAIN with start held high, then fresh run and an ignored start pulse.
    e = cyc + 1;
    bus0.num_tiles = 8'd1; bus0.start = 1'b1;
    push_run(0, e, 1, 30, 8, 16, 15, 1);
    push_zero(0, e + 30, e + 32);
    while (cyc < e + 29) step();
    rst = 1'b1;
    while (cyc < e + 32) step();
    rst = 1'b0;
    e1 = cyc + 1;
    push_run(0, e1, 1, len0 + 1, 8, 16, 15, 1);
    step();
    bus0.start = 1'b0;
    while (cyc < e1 + 18) step();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    while (cyc < e1 + len0 + 1) step();

    // Small-parameter instance, three tiles.
    len6 = run_len(4, 4, 7, 3);
    e = cyc + 1;
    bus1.num_tiles = 8'd3; bus1.start = 1'b1;
    push_run(1, e, 1, len6 + 1, 4, 4, 7, 3);
    step();
    bus1.start = 1'b0;
    repeat (len6 + 2) step();

    // Maximum tile count must complete without the tile counter wrapping.
    len255 = run_len(4, 4, 7, 255);
    e = cyc + 1;
    bus1.num_tiles = 8'd255; bus1.start = 1'b1;
    push_run(1, e, 1, len255 + 1, 4, 4, 7, 255);
    step();
    bus1.start = 1'b0;
    while (cyc < e + 100) step();
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    while (cyc < e + len255 + 1) step();

    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) step();
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got %0d/%0d entries left required 0/0", q0.size(), q1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
